cpu_idecode: RTL and testbench

- Instruction-decode front end; the consumer side of the fetch-to-decode instruction buffer interface.
- Takes the 16-bit instruction word and 32-bit trailing data word presented by fetch, each with its own valid flag.
- Decides the instruction length (16 or 48 bits) and returns used-insn / used-data strobes so fetch can advance its buffer index.
- Registers decoded fields into a one-entry decode/execute pipeline register with stall and flush.

---
 rtl/cpu_idecode_if.sv | 11 +
 rtl/cpu_idecode.sv | 88 ++++++++
 tb/tb_cpu_idecode.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_idecode_if.sv
// cpu_idecode_if: fetch-to-decode instruction buffer handshake (insn/data words with valids, used strobes back)
interface cpu_idecode_if;
  logic [15:0] insn;
  logic [31:0] insn_data;
  logic        insn_valid;
  logic        insn_data_valid;
  logic        used_insn;
  logic        used_data;
  modport master (output insn, insn_data, insn_valid, insn_data_valid, input used_insn, used_data);
  modport slave (input insn, insn_data, insn_valid, insn_data_valid, output used_insn, used_data);
endinterface

// File: rtl/cpu_idecode.sv
// cpu_idecode: decode front end (ifid slave port, 16/48-bit length, used strobes, stall/flush idex register, stall_cnt_o; CPU_IDECODE_ILLEGAL_EN adds idex_illegal_o)
module cpu_idecode #(
  parameter logic [7:0] BOOT_OPCODE_NOP = 8'h0f
) (
  input  logic         clk_i,
  input  logic         rst_i,
  cpu_idecode_if.slave ifid,
  input  logic         exid_stall_i,
  input  logic         flush_i,
  output logic         idex_valid_o,
  output logic [1:0]   idex_form_o,
  output logic [7:0]   idex_op_o,
  output logic [3:0]   idex_rA_o,
  output logic [3:0]   idex_rB_o,
  output logic [31:0]  idex_imm_o,
  output logic         idex_long_o,
  output logic [15:0]  stall_cnt_o
`ifdef CPU_IDECODE_ILLEGAL_EN
  ,
  output logic         idex_illegal_o
`endif
);
  typedef enum logic [1:0] {RUN, WAIT_DATA, FLUSH} state_t;
  state_t state, nxt;
  logic [15:0] i;
  logic f1, lng, accept, take;
  logic [1:0] form;
  logic [7:0] op;
  logic [3:0] ra, rb;
  logic [31:0] imm;
  assign i = ifid.insn;
  assign f1 = !i[15];
  assign lng = f1 && (i[15:8] inside {8'h01, 8'h03, 8'h08, 8'h09, 8'h0c, 8'h0d, 8'h1a, 8'h1b, 8'h1d,
                                      8'h1e, 8'h20, 8'h22, 8'h23, 8'h24, 8'h25, 8'h36, 8'h37, 8'h38, 8'h39});
  assign form = f1 ? 2'd0 : {1'b1, i[14]};
  assign op = f1 ? i[15:8] : i[14] ? {4'h0, i[13:10]} : {6'h0, i[13:12]};
  assign ra = f1 ? i[7:4] : i[14] ? 4'h0 : i[11:8];
  assign rb = f1 ? i[3:0] : 4'h0;
  assign imm = f1 ? (lng ? ifid.insn_data : 32'h0) : i[14] ? {{21{i[9]}}, i[9:0], 1'b0} : {24'h0, i[7:0]};
`ifdef CPU_IDECODE_ILLEGAL_EN
  logic ill;
  assign ill = f1 ? (i[15:8] == 8'h00 || i[15:8] > 8'h39) : (i[14] && i[13:10] == 4'hf);
`endif
  assign accept = !idex_valid_o || !exid_stall_i;
  assign take = !rst_i && ifid.insn_valid && accept && !flush_i && state != FLUSH && (!lng || ifid.insn_data_valid);
  assign ifid.used_insn = take;
  assign ifid.used_data = take && lng;
  always_comb begin
    nxt = state;
    if (flush_i) nxt = FLUSH;
    else if (state == FLUSH || take || (state == WAIT_DATA && ifid.insn_valid && !lng)) nxt = RUN;
    else if (ifid.insn_valid && lng && accept) nxt = WAIT_DATA;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= RUN;
    else state <= nxt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      idex_valid_o <= 1'b0;
      idex_form_o <= 2'd0;
      idex_op_o <= BOOT_OPCODE_NOP;
      idex_rA_o <= 4'h0;
      idex_rB_o <= 4'h0;
      idex_imm_o <= 32'h0;
      idex_long_o <= 1'b0;
      stall_cnt_o <= 16'h0;
`ifdef CPU_IDECODE_ILLEGAL_EN
      idex_illegal_o <= 1'b0;
`endif
    end else begin
      if (nxt == WAIT_DATA && stall_cnt_o != 16'hffff) stall_cnt_o <= stall_cnt_o + 16'd1;
      if (flush_i) begin
        idex_valid_o <= 1'b0;
        idex_op_o <= BOOT_OPCODE_NOP;
      end else if (take) begin
        idex_valid_o <= 1'b1;
        idex_form_o <= form;
        idex_op_o <= op;
        idex_rA_o <= ra;
        idex_rB_o <= rb;
        idex_imm_o <= imm;
        idex_long_o <= lng;
`ifdef CPU_IDECODE_ILLEGAL_EN
        idex_illegal_o <= ill;
`endif
      end else if (accept) idex_valid_o <= 1'b0;
    end
endmodule

// File: tb/tb_cpu_idecode.sv
// tb_cpu_idecode: directed scenarios plus randomized run against a behavioural decode/pipeline model
module tb_cpu_idecode;
  logic clk_i = 1'b0, rst_i = 1'b1, exid_stall_i = 1'b0, flush_i = 1'b0;
  logic idex_valid_o, idex_long_o;
  logic [1:0] idex_form_o;
  logic [7:0] idex_op_o;
  logic [3:0] idex_rA_o, idex_rB_o;
  logic [31:0] idex_imm_o;
  logic [15:0] stall_cnt_o;
`ifdef CPU_IDECODE_ILLEGAL_EN
  logic idex_illegal_o;
`endif
  int n_cmp = 0, n_err = 0;
  cpu_idecode_if ifid();
  cpu_idecode dut (
    .clk_i(clk_i), .rst_i(rst_i), .ifid(ifid.slave), .exid_stall_i(exid_stall_i), .flush_i(flush_i),
    .idex_valid_o(idex_valid_o), .idex_form_o(idex_form_o), .idex_op_o(idex_op_o),
    .idex_rA_o(idex_rA_o), .idex_rB_o(idex_rB_o), .idex_imm_o(idex_imm_o),
    .idex_long_o(idex_long_o), .stall_cnt_o(stall_cnt_o)
`ifdef CPU_IDECODE_ILLEGAL_EN
    , .idex_illegal_o(idex_illegal_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  typedef struct packed {
    logic [1:0] form;
    logic [7:0] op;
    logic [3:0] ra, rb;
    logic [31:0] imm;
    logic lng;
    logic ill;
  } dec_t;
  localparam logic [7:0] LONGS [19] = '{8'h01, 8'h03, 8'h08, 8'h09, 8'h0c, 8'h0d, 8'h1a, 8'h1b, 8'h1d,
                                        8'h1e, 8'h20, 8'h22, 8'h23, 8'h24, 8'h25, 8'h36, 8'h37, 8'h38, 8'h39};
  function automatic logic is_long(input logic [7:0] o);
    for (int k = 0; k < 19; k++) if (LONGS[k] == o) return 1'b1;
    return 1'b0;
  endfunction
  function automatic dec_t dec(input logic [15:0] w, input logic [31:0] d);
    dec_t r;
    int s;
    r = '0;
    case (w[15:14])
      2'b10: begin
        r.form = 2; r.op = 8'(w[13:12]); r.ra = w[11:8]; r.imm = 32'(w[7:0]);
      end
      2'b11: begin
        s = int'(w[9:0]);
        if (w[9]) s = s - 1024;
        r.form = 3; r.op = 8'(w[13:10]); r.imm = 32'(s * 2); r.ill = (w[13:10] == 4'hf);
      end
      default: begin
        r.form = 0; r.op = w[15:8]; r.ra = w[7:4]; r.rb = w[3:0]; r.lng = is_long(w[15:8]);
        r.imm = r.lng ? d : 32'h0; r.ill = (w[15:8] == 8'h00) || (w[15:8] > 8'h39);
      end
    endcase
    return r;
  endfunction
  function automatic logic [15:0] gen_insn();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 3))
      0: w[15:8] = LONGS[$urandom_range(0, 18)];
      1: w[15] = 1'b0;
      2: w[15:14] = 2'b10;
      default: w[15:14] = 2'b11;
    endcase
    return w;
  endfunction
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input logic [15:0] w, input logic [31:0] d, input logic iv, input logic dv);
    ifid.insn = w;
    ifid.insn_data = d;
    ifid.insn_valid = iv;
    ifid.insn_data_valid = dv;
  endtask
  task automatic test_reset;
    logic [66:0] g, e;
    rst_i = 1'b1;
    drive(16'h0512, 32'h0, 1'b1, 1'b1);
    tick;
    g = {idex_valid_o, idex_form_o, idex_op_o, idex_rA_o, idex_rB_o, idex_imm_o, idex_long_o, stall_cnt_o};
    e = {1'b0, 2'd0, 8'h0f, 4'h0, 4'h0, 32'h0, 1'b0, 16'h0};
    n_cmp++; if (g !== e) begin n_err++; $display("FAIL reset_regs got %h want %h", g, e); end
    n_cmp++; if ({ifid.used_insn, ifid.used_data} !== 2'b00) begin n_err++; $display("FAIL reset_strobes got %b want 00", {ifid.used_insn, ifid.used_data}); end
    drive(16'h0, 32'h0, 1'b0, 1'b0);
    rst_i = 1'b0;
    tick;
  endtask
  task automatic test_short;
    logic [17:0] g, e;
    drive(16'h0512, 32'h0, 1'b1, 1'b0);
    #1;
    n_cmp++; if ({ifid.used_insn, ifid.used_data} !== 2'b10) begin n_err++; $display("FAIL short_strobes got %b want 10", {ifid.used_insn, ifid.used_data}); end
    tick;
    g = {idex_valid_o, idex_op_o, idex_rA_o, idex_rB_o, idex_long_o};
    e = {1'b1, 8'h05, 4'h1, 4'h2, 1'b0};
    n_cmp++; if (g !== e) begin n_err++; $display("FAIL short_regs got %h want %h", g, e); end
    drive(16'h0, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic test_long;
    logic [49:0] g, e;
    drive(16'h0120, 32'hdeadbeef, 1'b1, 1'b1);
    #1;
    n_cmp++; if ({ifid.used_insn, ifid.used_data} !== 2'b11) begin n_err++; $display("FAIL long_strobes got %b want 11", {ifid.used_insn, ifid.used_data}); end
    tick;
    g = {idex_valid_o, idex_op_o, idex_rA_o, idex_rB_o, idex_imm_o, idex_long_o};
    e = {1'b1, 8'h01, 4'h2, 4'h0, 32'hdeadbeef, 1'b1};
    n_cmp++; if (g !== e) begin n_err++; $display("FAIL long_regs got %h want %h", g, e); end
    drive(16'h0, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic test_wait_data;
    drive(16'h0120, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if ({ifid.used_insn, ifid.used_data} !== 2'b00) begin n_err++; $display("FAIL wait_strobes cycle %0d got %b want 00", k, {ifid.used_insn, ifid.used_data}); end
      tick;
    end
    n_cmp++; if ({idex_valid_o, stall_cnt_o} !== {1'b0, 16'd3}) begin n_err++; $display("FAIL wait_cnt got %h want %h", {idex_valid_o, stall_cnt_o}, {1'b0, 16'd3}); end
    drive(16'h0120, 32'hcafef00d, 1'b1, 1'b1);
    #1;
    n_cmp++; if ({ifid.used_insn, ifid.used_data} !== 2'b11) begin n_err++; $display("FAIL wait_release_strobes got %b want 11", {ifid.used_insn, ifid.used_data}); end
    tick;
    n_cmp++; if ({idex_valid_o, idex_imm_o, stall_cnt_o} !== {1'b1, 32'hcafef00d, 16'd3}) begin n_err++; $display("FAIL wait_release_regs got %h want %h", {idex_valid_o, idex_imm_o, stall_cnt_o}, {1'b1, 32'hcafef00d, 16'd3}); end
    drive(16'h0, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic test_stall;
    drive(16'h0512, 32'h0, 1'b1, 1'b0);
    tick;
    drive(16'h0634, 32'h0, 1'b1, 1'b0);
    exid_stall_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if ({ifid.used_insn, ifid.used_data} !== 2'b00) begin n_err++; $display("FAIL stall_strobes cycle %0d got %b want 00", k, {ifid.used_insn, ifid.used_data}); end
      tick;
      n_cmp++; if ({idex_valid_o, idex_op_o, idex_rA_o, idex_rB_o} !== {1'b1, 8'h05, 4'h1, 4'h2}) begin n_err++; $display("FAIL stall_hold cycle %0d got %h want %h", k, {idex_valid_o, idex_op_o, idex_rA_o, idex_rB_o}, {1'b1, 8'h05, 4'h1, 4'h2}); end
    end
    exid_stall_i = 1'b0;
    #1;
    n_cmp++; if ({ifid.used_insn, ifid.used_data} !== 2'b10) begin n_err++; $display("FAIL stall_release_strobes got %b want 10", {ifid.used_insn, ifid.used_data}); end
    tick;
    n_cmp++; if ({idex_valid_o, idex_op_o, idex_rA_o, idex_rB_o} !== {1'b1, 8'h06, 4'h3, 4'h4}) begin n_err++; $display("FAIL stall_release_regs got %h want %h", {idex_valid_o, idex_op_o, idex_rA_o, idex_rB_o}, {1'b1, 8'h06, 4'h3, 4'h4}); end
    drive(16'h0, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic test_flush;
    drive(16'h0120, 32'h12345678, 1'b1, 1'b0);
    tick;
    flush_i = 1'b1;
    ifid.insn_data_valid = 1'b1;
    #1;
    n_cmp++; if ({ifid.used_insn, ifid.used_data} !== 2'b00) begin n_err++; $display("FAIL flush_strobes got %b want 00", {ifid.used_insn, ifid.used_data}); end
    tick;
    flush_i = 1'b0;
    n_cmp++; if ({idex_valid_o, idex_op_o, stall_cnt_o} !== {1'b0, 8'h0f, 16'd4}) begin n_err++; $display("FAIL flush_regs got %h want %h", {idex_valid_o, idex_op_o, stall_cnt_o}, {1'b0, 8'h0f, 16'd4}); end
    #1;
    n_cmp++; if ({ifid.used_insn, ifid.used_data} !== 2'b00) begin n_err++; $display("FAIL flush_state_strobes got %b want 00", {ifid.used_insn, ifid.used_data}); end
    tick;
    #1;
    n_cmp++; if ({ifid.used_insn, ifid.used_data} !== 2'b11) begin n_err++; $display("FAIL after_flush_strobes got %b want 11", {ifid.used_insn, ifid.used_data}); end
    tick;
    n_cmp++; if ({idex_valid_o, idex_imm_o} !== {1'b1, 32'h12345678}) begin n_err++; $display("FAIL after_flush_regs got %h want %h", {idex_valid_o, idex_imm_o}, {1'b1, 32'h12345678}); end
    drive(16'h0, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic test_async_reset;
    logic [66:0] g, e;
    drive(16'hc3ff, 32'h0, 1'b1, 1'b0);
    #1;
    n_cmp++; if ({ifid.used_insn, ifid.used_data} !== 2'b10) begin n_err++; $display("FAIL form3_strobes got %b want 10", {ifid.used_insn, ifid.used_data}); end
    tick;
    g = {idex_valid_o, idex_form_o, idex_op_o, idex_rA_o, idex_rB_o, idex_imm_o, idex_long_o, 16'h0};
    e = {1'b1, 2'd3, 8'h00, 4'h0, 4'h0, 32'hfffffffe, 1'b0, 16'h0};
    n_cmp++; if (g !== e) begin n_err++; $display("FAIL form3_regs got %h want %h", g, e); end
    drive(16'h0120, 32'h0, 1'b1, 1'b0);
    tick;
    #2;
    rst_i = 1'b1;
    #1;
    g = {idex_valid_o, idex_form_o, idex_op_o, idex_rA_o, idex_rB_o, idex_imm_o, idex_long_o, stall_cnt_o};
    e = {1'b0, 2'd0, 8'h0f, 4'h0, 4'h0, 32'h0, 1'b0, 16'h0};
    n_cmp++; if (g !== e) begin n_err++; $display("FAIL async_reset_regs got %h want %h", g, e); end
    ifid.insn_data_valid = 1'b1;
    #1;
    n_cmp++; if ({ifid.used_insn, ifid.used_data} !== 2'b00) begin n_err++; $display("FAIL async_reset_strobes got %b want 00", {ifid.used_insn, ifid.used_data}); end
    tick;
    drive(16'h0, 32'h0, 1'b0, 1'b0);
    rst_i = 1'b0;
    tick;
  endtask
  task automatic test_random;
    logic m_valid, m_wait, m_fl, iv, dv, st, fl, acc, tk;
    logic [15:0] m_cnt, w;
    logic [31:0] dw;
    dec_t m_d, d;
    logic [67:0] g, e;
    m_valid = 0; m_wait = 0; m_fl = 0; m_cnt = 0; m_d = '0; m_d.op = 8'h0f; w = 16'h0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 4) w = gen_insn();
      dw = $urandom;
      iv = $urandom_range(0, 3) != 0;
      dv = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 9) < 3;
      fl = $urandom_range(0, 19) == 0;
      drive(w, dw, iv, dv);
      exid_stall_i = st;
      flush_i = fl;
      #1;
      d = dec(w, dw);
      acc = !m_valid || !st;
      tk = iv && acc && !fl && !m_fl && (!d.lng || dv);
      n_cmp++; if ({ifid.used_insn, ifid.used_data} !== {tk, tk && d.lng}) begin n_err++; $display("FAIL rand_strobes cycle %0d insn %h got %b want %b", k, w, {ifid.used_insn, ifid.used_data}, {tk, tk && d.lng}); end
      if (fl) begin
        m_valid = 0; m_d.op = 8'h0f; m_fl = 1; m_wait = 0;
      end else begin
        m_wait = !m_fl && !tk && (iv ? (d.lng && (acc || m_wait)) : m_wait);
        m_fl = 0;
        if (m_wait && m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
        if (tk) begin m_valid = 1; m_d = d; end
        else if (acc) m_valid = 0;
      end
      tick;
      g = {idex_valid_o, idex_form_o, idex_op_o, idex_rA_o, idex_rB_o, idex_imm_o, idex_long_o, stall_cnt_o, 1'b0};
      e = {m_valid, m_d.form, m_d.op, m_d.ra, m_d.rb, m_d.imm, m_d.lng, m_cnt, 1'b0};
`ifdef CPU_IDECODE_ILLEGAL_EN
      g[0] = idex_illegal_o;
      e[0] = m_d.ill;
`endif
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL rand_regs cycle %0d got %h want %h", k, g, e); end
    end
    exid_stall_i = 1'b0;
    flush_i = 1'b0;
    drive(16'h0, 32'h0, 1'b0, 1'b0);
    tick;
  endtask
  task automatic test_saturate;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    drive(16'h0120, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 65540; k++) tick;
    n_cmp++; if ({ifid.used_insn, stall_cnt_o} !== {1'b0, 16'hffff}) begin n_err++; $display("FAIL saturate got %h want %h", {ifid.used_insn, stall_cnt_o}, {1'b0, 16'hffff}); end
    drive(16'h0, 32'h0, 1'b0, 1'b0);
  endtask
  initial begin
    test_reset;
    test_short;
    test_long;
    test_wait_data;
    test_stall;
    test_flush;
    test_async_reset;
    test_random;
    test_saturate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
